// File: rtl/rnd_lanes_pipe.sv
// Multi-lane two-stage mantissa rounder (RNE/RTZ/RNA/stochastic) with valid/ready and a saturating overflow counter.
// Stochastic mode 3 and its LFSR are built only when RND_STOCH_EN is defined; otherwise mode 3 rounds as RNE.
module rnd_lanes_pipe #(
  parameter int unsigned width_i   = 24,
  parameter int unsigned width_o   = 4,
  parameter int unsigned lanes     = 4,
  parameter int unsigned cnt_w     = 16,
  parameter logic [31:0] lfsr_seed = 32'hACE1_2468
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [lanes*width_i-1:0]   i_num,
  input  logic [1:0]                 i_mode,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [lanes*width_o-1:0]   o_man,
  output logic [lanes-1:0]           o_ofl,
  input  logic                       i_clr,
  output logic [cnt_w-1:0]           o_ofl_cnt
);

  localparam int unsigned K  = width_i - width_o;
  localparam int unsigned PW = $clog2(lanes + 1);
  localparam int unsigned SW = cnt_w + PW + 1;
  localparam logic [SW-1:0] CNT_MAX = (SW'(1) << cnt_w) - SW'(1);

  typedef enum logic [1:0] {
    MODE_RNE = 2'd0,
    MODE_RTZ = 2'd1,
    MODE_RNA = 2'd2,
    MODE_STO = 2'd3
  } mode_e;

  logic                     s1_valid;
  logic [lanes*width_o-1:0] s1_t;
  logic [lanes-1:0]         s1_inc;
  logic [lanes-1:0]         inc_c;
  logic                     s1_load;
  logic                     s2_load;

  assign s2_load = !o_valid || i_ready;
  assign s1_load = !s1_valid || s2_load;
  assign o_ready = s1_load;

`ifdef RND_STOCH_EN
  logic [31:0]      lfsr;
  logic [lanes-1:0] sto_carry;
  logic [63:0]      rot_w;
  logic [31:0]      rot;
  logic [K:0]       dsum;

  // Galois form, taps 32,22,2,1; advances only on accepted beats
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lfsr <= lfsr_seed;
    end else if (i_valid && s1_load) begin
      lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0000_0000);
    end
  end

  always_comb begin
    sto_carry = '0;
    rot_w     = '0;
    rot       = '0;
    dsum      = '0;
    for (int unsigned n = 0; n < lanes; n++) begin
      rot_w        = {lfsr, lfsr} << ((7 * n) % 32);
      rot          = rot_w[63:32];
      dsum         = {1'b0, i_num[n*width_i +: K]} + {1'b0, rot[K-1:0]};
      sto_carry[n] = dsum[K];
    end
  end
`endif

  logic [width_i-1:0] lane_num;
  logic               rnd_g;
  logic               rnd_s;
  logic               rnd_l;

  always_comb begin
    inc_c    = '0;
    lane_num = '0;
    rnd_g    = 1'b0;
    rnd_s    = 1'b0;
    rnd_l    = 1'b0;
    for (int unsigned n = 0; n < lanes; n++) begin
      lane_num = i_num[n*width_i +: width_i];
      rnd_g    = lane_num[K-1];
      rnd_s    = |lane_num[K-2:0];
      rnd_l    = lane_num[K];
      case (mode_e'(i_mode))
        MODE_RTZ: inc_c[n] = 1'b0;
        MODE_RNA: inc_c[n] = rnd_g;
`ifdef RND_STOCH_EN
        MODE_STO: inc_c[n] = sto_carry[n];
`endif
        default:  inc_c[n] = rnd_g & (rnd_l | rnd_s);
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_t     <= '0;
      s1_inc   <= '0;
    end else if (s1_load) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        for (int unsigned n = 0; n < lanes; n++) begin
          s1_t[n*width_o +: width_o] <= i_num[n*width_i + K +: width_o];
        end
        s1_inc <= inc_c;
      end
    end
  end

  logic [lanes*width_o-1:0] man_c;
  logic [lanes-1:0]         ofl_c;
  logic [width_o:0]         lane_sum;

  always_comb begin
    man_c    = '0;
    ofl_c    = '0;
    lane_sum = '0;
    for (int unsigned n = 0; n < lanes; n++) begin
      lane_sum = {1'b0, s1_t[n*width_o +: width_o]} + {{width_o{1'b0}}, s1_inc[n]};
      man_c[n*width_o +: width_o] = lane_sum[width_o-1:0];
      ofl_c[n] = lane_sum[width_o];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_man   <= '0;
      o_ofl   <= '0;
    end else if (s2_load) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_man <= man_c;
        o_ofl <= ofl_c;
      end
    end
  end

  logic [PW-1:0]    pop;
  logic [SW-1:0]    cnt_base;
  logic [SW-1:0]    cnt_sum;
  logic [cnt_w-1:0] cnt_nxt;

  // clear coinciding with a handshake drops the old count but keeps this beat's overflows
  always_comb begin
    pop = '0;
    for (int unsigned n = 0; n < lanes; n++) begin
      pop = pop + PW'(o_ofl[n]);
    end
    cnt_base = i_clr ? '0 : SW'(o_ofl_cnt);
    cnt_sum  = cnt_base + SW'(pop);
    cnt_nxt  = (cnt_sum > CNT_MAX) ? CNT_MAX[cnt_w-1:0] : cnt_sum[cnt_w-1:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ofl_cnt <= '0;
    end else if (o_valid && i_ready) begin
      o_ofl_cnt <= cnt_nxt;
    end else if (i_clr) begin
      o_ofl_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_rnd_lanes_pipe.sv
// Directed bench for rnd_lanes_pipe (width_i=8, width_o=4, lanes=2, cnt_w=4); stochastic checks need RND_STOCH_EN.
module tb_rnd_lanes_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_num;
  logic [1:0]  i_mode;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_man;
  logic [1:0]  o_ofl;
  logic        i_clr;
  logic [3:0]  o_ofl_cnt;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rnd_lanes_pipe #(
    .width_i (8),
    .width_o (4),
    .lanes   (2),
    .cnt_w   (4)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_num     (i_num),
    .i_mode    (i_mode),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_man     (o_man),
    .o_ofl     (o_ofl),
    .i_clr     (i_clr),
    .o_ofl_cnt (o_ofl_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [15:0] n, input logic [1:0] m);
    @(negedge clk);
    i_valid = v;
    i_num   = n;
    i_mode  = m;
  endtask

  // returns {ofl, man} for one 8-bit lane rounded to 4 bits
  function automatic logic [4:0] model(input logic [7:0] x, input logic [1:0] m);
    int t;
    int f;
    int up;
    t = int'(x) / 16;
    f = int'(x) % 16;
    case (m)
      2'd1:    up = 0;
      2'd2:    up = (f >= 8) ? 1 : 0;
      default: up = ((f > 8) || (f == 8 && (t % 2) == 1)) ? 1 : 0;
    endcase
    return 5'(t + up);
  endfunction

  logic [4:0]  e0;
  logic [4:0]  e1;
  logic [9:0]  exp_q[$];
  logic [9:0]  ef;
  logic [15:0] rpat;
  logic [7:0]  held_man;
  logic [1:0]  held_ofl;
  logic [15:0] vec;
  bit          stalled;
  bit          seen;
  int          sent;
  int          got;
  int          cyc;

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_num = '0; i_mode = '0; i_ready = 1'b1; i_clr = 1'b0;
    #12;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_ready", 32'(o_ready), 32'd1);
    check("rst_o_man",   32'(o_man),   32'd0);
    check("rst_o_ofl",   32'(o_ofl),   32'd0);
    check("rst_cnt",     32'(o_ofl_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // RNE ties/carry, then back-to-back mode changes
    drive(1'b1, 16'h4858, 2'd0);
    drive(1'b1, 16'h48F8, 2'd0);
    check("lat_no_early", 32'(o_valid), 32'd0);
    drive(1'b1, 16'h5F48, 2'd1);
    check("rne_valid", 32'(o_valid), 32'd1);
    check("rne_tie_man", 32'(o_man), 32'h46);
    check("rne_tie_ofl", 32'(o_ofl), 32'h0);
    drive(1'b1, 16'h5F48, 2'd2);
    check("rne_carry_man", 32'(o_man), 32'h40);
    check("rne_carry_ofl", 32'(o_ofl), 32'h1);
    check("cnt_before", 32'(o_ofl_cnt), 32'd0);
    drive(1'b1, 16'h5F48, 2'd1);
    check("rtz_man", 32'(o_man), 32'h54);
    check("cnt_after", 32'(o_ofl_cnt), 32'd1);
    drive(1'b1, 16'h5F48, 2'd3);
    check("rna_man", 32'(o_man), 32'h65);
    drive(1'b0, 16'h0000, 2'd0);
    check("rtz2_valid", 32'(o_valid), 32'd1);
    check("rtz2_man", 32'(o_man), 32'h54);
    drive(1'b0, 16'h0000, 2'd0);
    check("m3_valid", 32'(o_valid), 32'd1);
`ifndef RND_STOCH_EN
    check("m3_as_rne", 32'(o_man), 32'h64);
`endif
    drive(1'b0, 16'h0000, 2'd0);
    check("bubble_valid", 32'(o_valid), 32'd0);

    // backpressure stream against scoreboard
    rpat = 16'b1011_0010_1101_0110;
    sent = 0; got = 0; cyc = 0; stalled = 1'b0;
    while (got < 10 && cyc < 200) begin
      @(negedge clk);
      i_ready = rpat[cyc % 16];
      if (sent < 10) begin
        i_valid = 1'b1;
        i_num   = {8'(sent * 91 + 200), 8'(sent * 37 + 5)};
        i_mode  = 2'(sent % 3);
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (stalled) begin
        check("stall_man", 32'(o_man), 32'(held_man));
        check("stall_ofl", 32'(o_ofl), 32'(held_ofl));
      end
      if (!o_ready) check("ready_drop", 32'({o_valid, i_ready}), 32'b10);
      if (i_valid && o_ready) begin
        e0 = model(i_num[7:0], i_mode);
        e1 = model(i_num[15:8], i_mode);
        exp_q.push_back({e1[4], e0[4], e1[3:0], e0[3:0]});
        sent++;
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() > 0) begin
          ef = exp_q.pop_front();
          check("bp_man", 32'(o_man), 32'(ef[7:0]));
          check("bp_ofl", 32'(o_ofl), 32'(ef[9:8]));
        end else begin
          check("bp_spurious", 32'(o_valid), 32'd0);
        end
        got++;
      end
      stalled  = o_valid && !i_ready;
      held_man = o_man;
      held_ofl = o_ofl;
      cyc++;
    end
    check("bp_done", 32'(got), 32'd10);
    i_valid = 1'b0;
    i_ready = 1'b1;

    // counter saturation and clear
    @(negedge clk); i_clr = 1'b1;
    @(negedge clk); i_clr = 1'b0;
    check("clr_idle", 32'(o_ofl_cnt), 32'd0);
    for (int i = 0; i < 20; i++) drive(1'b1, 16'hF8F8, 2'd0);
    drive(1'b0, 16'h0000, 2'd0);
    repeat (3) @(negedge clk);
    check("cnt_sat", 32'(o_ofl_cnt), 32'hF);
    drive(1'b1, 16'hF8F8, 2'd0);
    drive(1'b0, 16'h0000, 2'd0);
    @(negedge clk);
    check("clr_beat_valid", 32'(o_valid), 32'd1);
    i_clr = 1'b1;
    @(negedge clk);
    i_clr = 1'b0;
    check("clr_with_beat", 32'(o_ofl_cnt), 32'd2);

`ifdef RND_STOCH_EN
    // reproducibility after reset and unbiased half-way rounding
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    drive(1'b1, 16'h4848, 2'd3);
    drive(1'b0, 16'h0000, 2'd0);
    @(negedge clk);
    held_man = o_man;
    got = 0;
    for (int i = 0; i < 4098; i++) begin
      drive(i < 4096, 16'h4848, 2'd3);
      if (o_valid) begin
        if (o_man[3:0] == 4'h5) got++;
        if (o_man[7:4] == 4'h5) got++;
      end
    end
    check("sto_frac", 32'((got * 100 >= 45 * 8192) && (got * 100 <= 55 * 8192)), 32'd1);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    drive(1'b1, 16'h4848, 2'd3);
    drive(1'b0, 16'h0000, 2'd0);
    @(negedge clk);
    check("sto_repeat", 32'(o_man), 32'(held_man));
`else
    for (int i = 0; i < 8; i++) begin
      vec = {8'(i * 16 + 8), 8'(i * 16 + 27)};
      drive(1'b1, vec, 2'd3);
      drive(1'b0, 16'h0000, 2'd0);
      @(negedge clk);
      e0 = model(vec[7:0], 2'd0);
      e1 = model(vec[15:8], 2'd0);
      check("m3_eq_m0", 32'({o_ofl, o_man}), 32'({e1[4], e0[4], e1[3:0], e0[3:0]}));
    end
`endif

    // async reset with two beats in flight
    drive(1'b1, 16'h4858, 2'd0);
    drive(1'b1, 16'h5F48, 2'd0);
    @(negedge clk);
    i_valid = 1'b0;
    check("inflight_valid", 32'(o_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_ready", 32'(o_ready), 32'd1);
    check("arst_man",   32'(o_man),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    check("no_stale", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/rnd_lanes_pipe.md
# rnd_lanes_pipe

Multi-lane, two-stage pipelined mantissa rounder with a runtime-selectable rounding mode and a valid/ready handshake. It rounds `lanes` unsigned augmented mantissas of `width_i` bits down to `width_o` bits per beat and flags carry-out per lane. It also keeps a saturating count of overflow events. It sits between the MX accumulator/normaliser and the element encoder, replacing the single combinational RNE rounder wherever throughput or mode choice is needed.

## Interface
Parameters:
- `width_i`, 24, input augmented mantissa width; requires width_i ≥ width_o + 2
- `width_o`, 4, output mantissa width (≥ 2)
- `lanes`, 4, parallel lanes per beat (≥ 1)
- `cnt_w`, 16, overflow counter width
- `lfsr_seed`, 32'hACE1_2468, stochastic LFSR reset value (nonzero)

Ports (clock, then reset):
- `i_clk`, in, 1, clock
- `i_rst`, in, 1, asynchronous reset, active-high
- `i_valid`, in, 1, input beat valid
- `o_ready`, out, 1, block can accept a beat
- `i_num`, in, lanes*width_i, lane n at [n*width_i +: width_i]
- `i_mode`, in, 2, rounding mode: 0 RNE, 1 RTZ, 2 RNA (ties up), 3 stochastic
- `o_valid`, out, 1, output beat valid
- `i_ready`, in, 1, downstream accepts the beat
- `o_man`, out, lanes*width_o, rounded mantissas, lane-packed like `i_num`
- `o_ofl`, out, lanes, per-lane carry-out; `o_man` for that lane is then all-zero (wrapped)
- `i_clr`, in, 1, synchronous clear of the overflow counter
- `o_ofl_cnt`, out, cnt_w, saturating count of lane overflows delivered

## Operation
- Definitions per lane: k = width_i−width_o; `t` = i_num[width_i−1 -: width_o]; `g` = bit k−1 (round); `s` = OR of bits k−2..0 (sticky); `d` = low k bits.
- Stage 1 (S1) registers `t`, a per-lane `inc` bit, and a valid flag.
  - RNE: inc = g & (t[0] | s).
  - RTZ: inc = 0.
  - RNA: inc = g.
  - Stochastic: inc = carry-out of (d + r), where r is the k low bits of the LFSR rotated left by 7·n bits for lane n.
- Stage 2 (S2) registers {o_ofl, o_man} = t + inc, computed at width_o+1 bits, per lane.
- Mode is sampled with the data. Mode changes between beats take effect with no bubble.
- LFSR: 32-bit Galois, taps 32,22,2,1. It steps once per accepted input beat (i_valid & o_ready) and holds otherwise. Requires k ≤ 32.
- Overflow counter: on each output handshake (o_valid & i_ready), add popcount(o_ofl) and saturate at 2^cnt_w−1. If i_clr coincides with a handshake, the counter loads that beat's popcount (clear wins over the prior value only).

## Timing
- Latency is 2 cycles from input handshake to o_valid, with no stalls.
- Throughput is one beat per cycle.
- Stage advance:
  - S2 loads when !o_valid | i_ready.
  - S1 loads when !s1_valid | S2 loads.
  - o_ready = !s1_valid | S2 loads (combinational from i_ready; no skid buffer).
- Under stall (o_valid & !i_ready), o_man, o_ofl and o_valid hold stable. No beat is dropped or duplicated.
- Reset values: o_valid 0, s1_valid 0, o_man 0, o_ofl 0, o_ofl_cnt 0, LFSR = lfsr_seed. o_ready is 1 after reset.
- Reset mid-operation discards all in-flight beats immediately. The LFSR restarts from the seed.
- i_valid low: pipeline bubbles propagate. Data registers may hold stale values but o_valid = 0.

## Configuration
- `RND_STOCH_EN` defined: mode 3 is stochastic rounding; LFSR is instantiated.
- `RND_STOCH_EN` undefined: no LFSR logic is built, and mode 3 behaves exactly as RNE (0). `lfsr_seed` is ignored.

## Test plan
- RNE ties and carries, width_i=8, width_o=4, lanes=2, mode 0.
  - Lanes 8'h58 and 8'h48 → o_man 4'h6 and 4'h4, o_ofl 0.
  - Lane 8'hF8 → o_man 4'h0, o_ofl 1, and o_ofl_cnt increments by 1.
- Modes on 8'h48 and 8'h5F, cycling beats in modes 1 and 2 back-to-back.
  - RTZ → 4'h4 and 4'h5.
  - RNA → 4'h5 and 4'h6.
  - One result per cycle, latency 2.
- Backpressure: stream 10 beats with i_ready toggling 1/0 pseudo-randomly.
  - Outputs match the scoreboard in order.
  - Outputs are stable while stalled.
  - o_ready drops only when both stages are full and i_ready = 0.
- Counter saturation with cnt_w=4: 20 all-overflow beats on 2 lanes.
  - o_ofl_cnt sticks at 4'hF.
  - i_clr together with an overflow beat → 2.
- Stochastic (macro defined): 4096 beats of d=k-bit half-value.
  - Round-up fraction lies within 0.45–0.55.
  - After reset, the first-beat results repeat exactly.
  - With the macro undefined, mode 3 results equal mode 0 results.
- Async reset asserted with 2 beats in flight: o_valid drops immediately, and no stale beat appears after release.
